// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bundle for restoring_divider.
// The master issues requests; the slave (the divider) returns results.
interface restoring_divider_if #(
    parameter int BW = 4
);
    logic          start;
    logic [BW-1:0] dividend;
    logic [BW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [BW-1:0] quotient;
    logic [BW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock using a
// (BW+1)-bit ripple-borrow trial subtractor, with a start/busy/done handshake.
module restoring_divider #(
    parameter int BW = 4
) (
    input logic               clk,
    input logic               rst,
    restoring_divider_if.slave bus
);
    localparam int CW = $clog2(BW);
    localparam logic [CW-1:0] LastCnt = CW'(BW - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] rem_q, rem_d;
    logic [BW-1:0] shreg_q, shreg_d;
    logic [BW-1:0] dvsr_q, dvsr_d;
    logic [BW-1:0] quo_q, quo_d;
    logic [BW-1:0] remout_q, remout_d;
    logic          dbz_q, dbz_d;

    // Trial subtraction Rs - {0,divisor}; cells indexed 1..BW+1, borrow[0] = 0.
    logic [BW+1:1] sub_a;
    logic [BW+1:1] sub_b;
    logic [BW:1]   sub_d;
    logic [BW+1:0] brw;

    assign sub_a  = {rem_q, shreg_q[BW-1]};
    assign sub_b  = {1'b0, dvsr_q};
    assign brw[0] = 1'b0;

    for (genvar i = 1; i <= BW + 1; i++) begin : g_cell
        if (i <= BW) begin : g_diff
            assign sub_d[i] = sub_a[i] ^ sub_b[i] ^ brw[i-1];
        end
        assign brw[i] = (~sub_a[i] & sub_b[i]) | (~(sub_a[i] ^ sub_b[i]) & brw[i-1]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        shreg_d  = shreg_q;
        dvsr_d   = dvsr_q;
        quo_d    = quo_q;
        remout_d = remout_q;
        dbz_d    = dbz_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    dvsr_d = bus.divisor;
                    dbz_d  = 1'b0;
                    if (bus.divisor != '0) begin
                        state_d = StRun;
                        shreg_d = bus.dividend;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d  = StDone;
                        quo_d    = '1;
                        remout_d = bus.dividend;
                        dbz_d    = 1'b1;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // Borrow out means Rs < divisor: keep Rs (restore), quotient bit 0.
                rem_d   = brw[BW+1] ? sub_a[BW:1] : sub_d[BW:1];
                shreg_d = {shreg_q[BW-2:0], ~brw[BW+1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    quo_d    = shreg_d;
                    remout_d = rem_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            shreg_q  <= '0;
            dvsr_q   <= '0;
            quo_q    <= '0;
            remout_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            shreg_q  <= shreg_d;
            dvsr_q   <= dvsr_d;
            quo_q    <= quo_d;
            remout_q <= remout_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = remout_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed and exhaustive checks of restoring_divider at BW=4.
module tb_restoring_divider;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    restoring_divider_if #(.BW(BW)) bus ();

    restoring_divider #(.BW(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done; returns cycles after the start edge and busy count.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (!bus.done && cyc < 40) begin
            if (bus.busy) nbusy++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input int a, input int b, input int qe, input int re,
                          input int dbze, input string tag);
        int cyc, nbusy, lat;
        lat = (b == 0) ? 0 : BW;
        bus.dividend = BW'(a);
        bus.divisor  = BW'(b);
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc, nbusy);
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy cycles"}, nbusy, lat);
        check({tag, " quotient"}, int'(bus.quotient), qe);
        check({tag, " remainder"}, int'(bus.remainder), re);
        check({tag, " dbz"}, int'(bus.div_by_zero), dbze);
        tick();
        check({tag, " done one cycle"}, int'(bus.done), 0);
    endtask

    initial begin
        int cyc, nbusy, gap;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        vecs.push_back('{a: 13, b: 3, q: 4, r: 1, dbz: 0});
        vecs.push_back('{a: 15, b: 1, q: 15, r: 0, dbz: 0});
        vecs.push_back('{a: 2, b: 7, q: 0, r: 2, dbz: 0});
        vecs.push_back('{a: 9, b: 0, q: 15, r: 9, dbz: 1});
        vecs.push_back('{a: 0, b: 5, q: 0, r: 0, dbz: 0});
        vecs.push_back('{a: 15, b: 15, q: 1, r: 0, dbz: 0});
        vecs.push_back('{a: 8, b: 3, q: 2, r: 2, dbz: 0});
        vecs.push_back('{a: 0, b: 0, q: 15, r: 0, dbz: 1});
        vecs.push_back('{a: 14, b: 5, q: 2, r: 4, dbz: 0});
        vecs.push_back('{a: 15, b: 8, q: 1, r: 7, dbz: 0});

        tick();
        tick();
        rst = 1'b0;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset quotient", int'(bus.quotient), 0);
        check("reset remainder", int'(bus.remainder), 0);
        check("reset dbz", int'(bus.div_by_zero), 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
                   $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));
        end

        // Start ignored while running: 6/2 proceeds, 15/4 discarded.
        bus.dividend = 4'd6;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.dividend = 4'd15;
        bus.divisor  = 4'd4;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc, nbusy);
        check("ignore latency", cyc + 2, BW);
        check("ignore quotient", int'(bus.quotient), 3);
        check("ignore remainder", int'(bus.remainder), 0);
        tick();

        // Back-to-back: start held high through done.
        bus.dividend = 4'd7;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        tick();
        wait_done(cyc, nbusy);
        check("b2b first latency", cyc, BW);
        check("b2b first quotient", int'(bus.quotient), 3);
        check("b2b first remainder", int'(bus.remainder), 1);
        tick();
        check("b2b restarted busy", int'(bus.busy), 1);
        wait_done(gap, nbusy);
        bus.start = 1'b0;
        check("b2b done spacing", gap + 1, BW + 1);
        check("b2b second quotient", int'(bus.quotient), 3);
        check("b2b second remainder", int'(bus.remainder), 1);
        tick();
        check("b2b back to idle", int'(bus.done) + int'(bus.busy), 0);

        // Reset during RUN cycle 2 aborts with no done.
        bus.dividend = 4'd14;
        bus.divisor  = 4'd5;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort quotient", int'(bus.quotient), 0);
        check("abort remainder", int'(bus.remainder), 0);
        check("abort dbz", int'(bus.div_by_zero), 0);
        nbusy = 0;
        for (int i = 0; i < BW + 2; i++) begin
            nbusy += int'(bus.done) + int'(bus.busy);
            tick();
        end
        check("abort stays idle", nbusy, 0);
        run_op(14, 5, 2, 4, 0, "after abort 14/5");

        // Exhaustive sweep against / and % plus the division invariant.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(a, b, a / b, a % b, 0, $sformatf("exh %0d/%0d", a, b));
                check($sformatf("exh %0d/%0d invariant", a, b),
                      int'(bus.quotient) * b + int'(bus.remainder), a);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
